// File: rtl/fp_det_pkg.sv
// Shared constants for the determinant job scheduler: opcodes, enqueue return codes, dispatch states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_det_pkg;

    // Custom-instruction opcodes carried in datab[31:30]
    localparam logic [1:0] OP_STATUS   = 2'b00;
    localparam logic [1:0] OP_ENQUEUE  = 2'b01;
    localparam logic [1:0] OP_FLUSH    = 2'b10;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    // Enqueue return codes
    localparam logic [31:0] ENQ_OK      = 32'd0;
    localparam logic [31:0] ENQ_FULL    = 32'd1;
    localparam logic [31:0] ENQ_BAD_DIM = 32'd2;

    localparam logic [31:0] RESERVED_RESULT = 32'hFFFF_FFFF;

    // Dispatch FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } disp_state_t;

    // One pending job as stored in the job FIFO
    typedef struct packed {
        logic [23:0] base;
        logic [7:0]  dim;
    } job_t;

endpackage

// File: rtl/det_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; head is visible combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; push+pop in one cycle keeps count.
//
// Ports: clk, reset (sync, active-high), clear (drop all entries), push/push_data,
//        pop, head (oldest entry), count ($clog2(DEPTH)+1 bits), full, empty.
module det_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Clear wins over push/pop. A pop in the clear cycle has already
    // delivered its head to the consumer, so dropping it here is correct.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fp_det_scheduler.sv
// Queues determinant jobs from a custom instruction, dispatches them one at a time to the engine, buffers results.
// Latency: done 1 cycle after start; eng_start 2 cycles after an enqueue into an idle scheduler; readdata 1 cycle after read.
// Backpressure: enqueue refused (code 1) when the job FIFO is full; dispatch held while no result slot is free.
//
// Ports: clk/reset; clk_en, start, dataa, datab -> done, result (custom instruction);
//        eng_start, eng_base, eng_dim <- eng_done, eng_result (engine handshake);
//        result_read -> result_readdata (Avalon pop); irq (result FIFO non-empty).
module fp_det_scheduler
    import fp_det_pkg::*;
#(
    parameter int          JOB_DEPTH         = 4,
    parameter logic [7:0]  DEFAULT_DIMENSION = 8'd16,
    parameter logic [7:0]  MAX_DIMENSION     = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic        eng_start,
    output logic [23:0] eng_base,
    output logic [7:0]  eng_dim,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    input  logic        result_read,
    output logic [31:0] result_readdata,
    output logic        irq
);
    localparam int CW = $clog2(JOB_DEPTH) + 1;

    disp_state_t   state;
    logic          ci_fire;
    logic [1:0]    opcode;
    logic [7:0]    enq_dim;
    logic          dim_ok;
    logic          busy;
    logic [31:0]   ci_result;

    logic          job_push;
    logic          job_clear;
    logic          issue_pop;
    job_t          job_in;
    logic [31:0]   job_head_dat;
    job_t          job_head;
    logic [CW-1:0] job_count;
    logic          job_full;
    logic          job_empty;

    logic          res_push;
    logic          res_pop;
    logic [31:0]   res_head;
    logic [CW-1:0] res_count;
    logic          res_full;
    logic          res_empty;

    logic          unused_bits;
    assign unused_bits = ^{dataa[31:24], datab[29:8]};

    assign ci_fire  = start && clk_en;
    assign opcode   = datab[31:30];
    assign enq_dim  = (datab[7:0] == 8'd0) ? DEFAULT_DIMENSION : datab[7:0];
    assign dim_ok   = (enq_dim >= 8'd2) && (enq_dim <= MAX_DIMENSION);
    assign busy     = (state != ST_IDLE);

    assign job_in    = '{base: dataa[23:0], dim: enq_dim};
    assign job_head  = job_t'(job_head_dat);
    assign job_push  = ci_fire && (opcode == OP_ENQUEUE) && !job_full && dim_ok;
    assign job_clear = ci_fire && (opcode == OP_FLUSH);
    // A flush can land in the same cycle IDLE->ISSUE was decided, so ISSUE
    // may find the queue already empty; only pop when there is a job.
    assign issue_pop = (state == ST_ISSUE) && !job_empty;

    // eng_done only counts while a job is actually running.
    assign res_push = (state == ST_RUN) && eng_done;
    assign res_pop  = result_read && !res_empty;

    det_sync_fifo #(.WIDTH(32), .DEPTH(JOB_DEPTH)) u_job_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (job_clear),
        .push      (job_push),
        .push_data (job_in),
        .pop       (issue_pop),
        .head      (job_head_dat),
        .count     (job_count),
        .full      (job_full),
        .empty     (job_empty)
    );

    det_sync_fifo #(.WIDTH(32), .DEPTH(JOB_DEPTH)) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (res_push),
        .push_data (eng_result),
        .pop       (res_pop),
        .head      (res_head),
        .count     (res_count),
        .full      (res_full),
        .empty     (res_empty)
    );

    // Custom-instruction response, registered below into result.
    always_comb begin
        ci_result = '0;
        case (opcode)
            OP_STATUS: begin
                ci_result = {16'd0, busy, 3'd0, 4'(job_count), 4'd0, 4'(res_count)};
            end
            OP_ENQUEUE: begin
                if (job_full) begin
                    ci_result = ENQ_FULL;
                end else if (!dim_ok) begin
                    ci_result = ENQ_BAD_DIM;
                end else begin
                    ci_result = ENQ_OK;
                end
            end
            OP_FLUSH: begin
                // A job popped by ISSUE this cycle still launches, so it is not counted as discarded.
                ci_result = 32'(job_count - CW'(issue_pop));
            end
            OP_RESERVED: begin
                ci_result = RESERVED_RESULT;
            end
            default: begin
                ci_result = RESERVED_RESULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done   <= ci_fire;
            result <= ci_fire ? ci_result : '0;
        end
    end

    // Dispatch FSM. Leaving IDLE only while the result FIFO has a free slot
    // reserves that slot for the job: the result count cannot grow again
    // until this job's own eng_done, so that push always fits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            eng_start <= 1'b0;
            eng_base  <= '0;
            eng_dim   <= '0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!job_empty && !res_full) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_pop) begin
                        eng_base  <= job_head.base;
                        eng_dim   <= job_head.dim;
                        eng_start <= 1'b1;
                        state     <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (eng_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_readdata <= '0;
            irq             <= 1'b0;
        end else begin
            irq <= (res_count != '0);
            if (result_read) begin
                result_readdata <= res_empty ? '0 : res_head;
            end
        end
    end

endmodule

// File: tb/tb_fp_det_scheduler.sv
module tb_fp_det_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;
    logic        eng_start;
    logic [23:0] eng_base;
    logic [7:0]  eng_dim;
    logic        eng_done;
    logic [31:0] eng_result;
    logic        result_read;
    logic [31:0] result_readdata;
    logic        irq;

    fp_det_scheduler #(
        .JOB_DEPTH         (4),
        .DEFAULT_DIMENSION (8'd16),
        .MAX_DIMENSION     (8'd32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_en          (clk_en),
        .start           (start),
        .dataa           (dataa),
        .datab           (datab),
        .done            (done),
        .result          (result),
        .eng_start       (eng_start),
        .eng_base        (eng_base),
        .eng_dim         (eng_dim),
        .eng_done        (eng_done),
        .eng_result      (eng_result),
        .result_read     (result_read),
        .result_readdata (result_readdata),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_starts = 0;
    int          n0;
    bit          inflight = 1'b0;

    // Scoreboards: custom-instruction responses, pending jobs, buffered results.
    logic [31:0] ciq[$];
    string       ciq_tag[$];
    logic [31:0] jq[$];
    logic [31:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end 1 time unit after a falling edge.
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic ci(input string tag, input logic [1:0] op, input logic [23:0] base,
                      input logic [7:0] dimf, input logic [31:0] exp, input bit en);
        dataa  = {8'hA5, base};
        datab  = {op, 22'h2AAAAA & 22'h0, dimf};
        start  = 1'b1;
        clk_en = en;
        if (en) begin
            ciq.push_back(exp);
            ciq_tag.push_back(tag);
        end
        @(negedge clk);
        #1;
        start  = 1'b0;
        clk_en = 1'b0;
        dataa  = '0;
        datab  = '0;
    endtask

    task automatic enq(input string tag, input logic [23:0] base, input logic [7:0] dimf,
                       input logic [31:0] exp);
        logic [7:0] d;
        d = (dimf == 8'd0) ? 8'd16 : dimf;
        if (exp == 32'd0) jq.push_back({base, d});
        ci(tag, 2'b01, base, dimf, exp, 1'b1);
    endtask

    task automatic flush(input string tag, input logic [31:0] exp, input int keep);
        while (jq.size() > keep) void'(jq.pop_back());
        ci(tag, 2'b10, 24'd0, 8'd0, exp, 1'b1);
    endtask

    task automatic status(input string tag);
        logic [3:0]  jn;
        logic [3:0]  rn;
        logic [31:0] e;
        jn = 4'(jq.size());
        rn = 4'(rq.size());
        e  = {16'd0, inflight, 3'd0, jn, 4'd0, rn};
        ci(tag, 2'b00, 24'd0, 8'd0, e, 1'b1);
    endtask

    task automatic fin(input logic [31:0] v, input bit accepted);
        eng_done   = 1'b1;
        eng_result = v;
        @(negedge clk);
        #1;
        eng_done   = 1'b0;
        eng_result = '0;
        if (accepted) begin
            rq.push_back(v);
            inflight = 1'b0;
        end
    endtask

    task automatic rd(input string tag);
        logic [31:0] e;
        e = (rq.size() != 0) ? rq.pop_front() : 32'd0;
        result_read = 1'b1;
        @(negedge clk);
        chk(tag, result_readdata, e);
        #1;
        result_read = 1'b0;
    endtask

    task automatic fin_rd(input string tag, input logic [31:0] v);
        logic [31:0] e;
        e = (rq.size() != 0) ? rq.pop_front() : 32'd0;
        eng_done    = 1'b1;
        eng_result  = v;
        result_read = 1'b1;
        @(negedge clk);
        chk(tag, result_readdata, e);
        #1;
        eng_done    = 1'b0;
        eng_result  = '0;
        result_read = 1'b0;
        rq.push_back(v);
        inflight = 1'b0;
    endtask

    // Output monitor: custom-instruction responses and engine launches.
    always @(negedge clk) begin : mon
        string       t;
        logic [31:0] w;
        if (!reset) begin
            if (done) begin
                if (ciq.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    t = ciq_tag.pop_front();
                    chk(t, result, ciq.pop_front());
                end
            end
            if (eng_start) begin
                if (jq.size() == 0) begin
                    chk("eng_start_unexpected", 32'(eng_start), 32'd0);
                end else begin
                    w = jq.pop_front();
                    chk("eng_base", 32'(eng_base), 32'(w[31:8]));
                    chk("eng_dim", 32'(eng_dim), 32'(w[7:0]));
                    inflight = 1'b1;
                    n_starts++;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        clk_en      = 1'b0;
        start       = 1'b0;
        dataa       = '0;
        datab       = '0;
        eng_done    = 1'b0;
        eng_result  = '0;
        result_read = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_eng_start", 32'(eng_start), 32'd0);
        chk("rst_eng_base", 32'(eng_base), 32'd0);
        chk("rst_eng_dim", 32'(eng_dim), 32'd0);
        chk("rst_readdata", result_readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        #1;
        reset = 1'b0;
        status("st_reset");

        // Enqueue into an idle scheduler: launch two cycles after done
        enq("enq_a", 24'h000100, 8'd4, 32'd0);
        @(negedge clk);
        chk("start_gap", 32'(eng_start), 32'd0);
        @(negedge clk);
        chk("start_at2", 32'(eng_start), 32'd1);
        chk("start_base", 32'(eng_base), 32'h100);
        chk("start_dim", 32'(eng_dim), 32'd4);
        #1;
        status("st_busy");

        // Result path and irq timing
        fin(32'h4080_0000, 1'b1);
        chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        #1;
        rd("rd_det");
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_fall", 32'(irq), 32'd0);
        #1;
        rd("rd_empty");

        // Dimension handling
        enq("enq_dim0", 24'h000200, 8'd0, 32'd0);
        settle(4);
        chk("dim_default", 32'(eng_dim), 32'd16);
        enq("enq_dim1", 24'h000300, 8'd1, 32'd2);
        enq("enq_dim33", 24'h000300, 8'd33, 32'd2);
        enq("enq_dim32", 24'h000300, 8'd32, 32'd0);
        enq("enq_dim2", 24'h000400, 8'd2, 32'd0);

        // Fill the job FIFO with the engine busy
        enq("enq_q3", 24'h000500, 8'd8, 32'd0);
        enq("enq_q4", 24'h000600, 8'd8, 32'd0);
        enq("enq_full", 24'h000700, 8'd8, 32'd1);
        enq("enq_full_prio", 24'h000700, 8'd33, 32'd1);
        status("st_full");
        ci("op_rsvd", 2'b11, 24'h000123, 8'd5, 32'hFFFF_FFFF, 1'b1);
        status("st_after_rsvd");

        // Four unread results block dispatch; one read allows exactly one launch
        fin(32'h0000_0011, 1'b1);
        settle(4);
        fin(32'h0000_0022, 1'b1);
        settle(4);
        fin(32'h0000_0033, 1'b1);
        settle(4);
        fin(32'h0000_0044, 1'b1);
        enq("enq_blocked", 24'h000700, 8'd3, 32'd0);
        n0 = n_starts;
        settle(10);
        chk("no_dispatch_full", n_starts, n0);
        chk("irq_full", 32'(irq), 32'd1);
        status("st_blocked");
        rd("rd_r1");
        settle(4);
        chk("one_dispatch", n_starts, n0 + 1);
        status("st_unblocked");

        // Concurrent push and pop on the result FIFO
        fin_rd("rd_concurrent", 32'h0000_0055);
        settle(4);
        status("st_concurrent");

        // Flush with results full and three jobs stuck
        fin(32'h0000_0066, 1'b1);
        enq("enq_f1", 24'h000800, 8'd4, 32'd0);
        enq("enq_f2", 24'h000900, 8'd4, 32'd0);
        enq("enq_f3", 24'h000A00, 8'd4, 32'd0);
        settle(3);
        flush("flush_3", 32'd3, 0);
        status("st_flushed");
        rd("rd_q1");
        rd("rd_q2");
        rd("rd_q3");
        rd("rd_q4");
        rd("rd_q_empty");
        settle(2);
        chk("irq_drained", 32'(irq), 32'd0);

        // Flush in the same cycle as the ISSUE pop: popped job still launches
        enq("race_a", 24'h000B00, 8'd5, 32'd0);
        enq("race_b", 24'h000C00, 8'd6, 32'd0);
        flush("flush_race", 32'd1, 1);
        settle(4);
        status("st_race");

        // start with clk_en low is ignored
        ci("ce_low", 2'b01, 24'h000D00, 8'd4, 32'd0, 1'b0);
        settle(4);
        status("st_ce_low");

        // Reset while RUN, then a stray eng_done
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
        jq.delete();
        rq.delete();
        inflight = 1'b0;
        n0 = n_starts;
        fin(32'h0000_0077, 1'b0);
        settle(3);
        chk("irq_after_reset", 32'(irq), 32'd0);
        chk("base_after_reset", 32'(eng_base), 32'd0);
        status("st_after_reset");
        rd("rd_after_reset");
        settle(3);
        chk("no_start_after_reset", n_starts, n0);
        chk("ci_drained", ciq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
